temp_bcd_display: RTL and testbench
===================================

Name: temp_bcd_display

Overview:
- Downstream consumer of the I2C temperature read path. Takes the signed 8-bit temperature byte (°C, two's complement) delivered on data_rd with a one-cycle valid strobe.
- Converts the byte to sign plus three BCD digits with a sequential double-dabble engine.
- Drives a 4-digit multiplexed, active-low seven-segment display (seg/an) on the board.

Parameters:
- REFRESH_DIV, 50000, clk cycles each digit stays lit before the scan advances; must be ≥2.
- STALE_CYCLES, 100000000, cycles without data_valid before the display goes stale (used only with the optional feature).

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- data_rd  in  8  temperature byte, signed °C.
- data_valid  in  1  one-cycle strobe; data_rd is qualified on the same cycle.
- seg  out  8  segments, active low; seg[6:0]=g..a, seg[7]=dp (dp always off, i.e. 1).
- an  out  4  digit anodes, active-low one-hot; an[0]=rightmost digit.
- busy  out  1  conversion in progress.
- value_valid  out  1  high once at least one conversion has been committed.

Behaviour:
- Reset values: seg=8'hFF, an=4'hF, busy=0, value_valid=0. Display digit registers = four dashes. Pending flag=0. FSM=IDLE. Refresh counter and digit index = 0.

FSM
- IDLE:
  - data_valid=1 → latch sign=data_rd[7] and mag=|data_rd| as 8-bit unsigned (-128 → 128).
  - Clear the 12-bit BCD shift register.
  - Go to CONV.
- CONV:
  - 8 shift-add-3 iterations, one per cycle (iteration counter 0..7).
  - Before each shift, add 3 to any BCD nibble ≥5.
  - After iteration 7 → LOAD.
- LOAD (1 cycle):
  - Commit sign/hundreds/tens/units to the display registers; set value_valid=1.
  - If pending=1 → load the pending byte as in IDLE, clear pending, go to CONV.
  - Otherwise go to IDLE.
- busy=1 exactly while the FSM is in CONV or LOAD.
- Latency: data_valid sampled at edge N → display registers hold the new value after edge N+9.
- data_valid during CONV/LOAD:
  - The byte goes into a one-deep pending register and pending is set.
  - A later strobe before it is consumed overwrites it; the newest value wins and nothing else is queued.
- data_valid in the same cycle as LOAD commits: the strobe is captured as pending and consumed immediately by that LOAD.

Digit mapping (committed value)
- digit3: '-' if negative, else blank.
- digit2: hundreds, blanked if 0.
- digit1: tens, blanked if hundreds=0 and tens=0.
- digit0: units, always shown.

Scan
- Refresh counter counts 0..REFRESH_DIV-1. On wrap, digit index increments mod 4.
- an and seg register the selected digit on that same edge, so an and seg always change together.
- First lit digit (an=4'b1110) appears REFRESH_DIV cycles after reset release.

Glyphs (active low)
- 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
- '-'=BF, blank=FF.

Reset mid-conversion: aborts the conversion, discards pending, and restores the reset values on the next edge.

Optional Feature:
- TEMP_STALE_EN defined:
  - A counter clears on every data_valid.
  - When it reaches STALE_CYCLES it saturates: all four digits show '-' and value_valid drops to 0.
  - The next commit restores normal display.
  - The counter runs from reset, so a sensor that never responds shows dashes.
- Not defined: the last committed value is held indefinitely and there is no counter logic.

Decomposition:
- Package temp_disp_pkg holds:
  - the FSM state enum (IDLE, CONV, LOAD);
  - the glyph constants (GLYPH_0..GLYPH_9, GLYPH_DASH, GLYPH_BLANK);
  - a function nibble_to_seg.
- One sub-module, bcd8_dd: the sequential 8-bit double-dabble engine.
  - Inputs: start, mag.
  - Outputs: done, hundreds, tens, units.
- The top block keeps the FSM/pending logic, the digit mapping and the scan mux.

Test Plan (REFRESH_DIV=4, STALE_CYCLES=200):
- Reset, then no input for 20 cycles → an=F then 4'b1110 at cycle 4; all digits FF except dashes BF; value_valid=0.
- data_valid with 8'h19 (25) → busy high for 9 cycles; digits blank, blank, A4, 92; value_valid=1 after edge N+9.
- 8'h80 (-128) → digits BF, F9, A4, 80. Then 8'hFF (-1) → BF, FF, FF, F9.
- Strobe 8'h05 then strobes 8'h0A and 8'h64 during CONV → 5 is committed, then only 100 (F9, C0, C0 on digits 2..0); 10 is never displayed.
- Assert reset mid-CONV at iteration 4 → next edge: seg=FF, an=F, busy=0, pending cleared; the following strobe converts normally.
- With TEMP_STALE_EN: commit 8'h00, then no strobe for 200 cycles → all dashes and value_valid=0; next strobe restores digits after 9 cycles.

Source files
------------

// File: rtl/temp_disp_pkg.sv
// temp_disp_pkg
// Shared definitions for the temperature display slice: the control FSM
// state type, the active-low seven-segment glyph codes (seg[6:0]=g..a,
// seg[7]=dp, decimal point always dark) and a nibble-to-glyph helper.
// Optional build macro used elsewhere in this slice: TEMP_STALE_EN.
package temp_disp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } state_e;

    localparam logic [7:0] GLYPH_0     = 8'hC0;
    localparam logic [7:0] GLYPH_1     = 8'hF9;
    localparam logic [7:0] GLYPH_2     = 8'hA4;
    localparam logic [7:0] GLYPH_3     = 8'hB0;
    localparam logic [7:0] GLYPH_4     = 8'h99;
    localparam logic [7:0] GLYPH_5     = 8'h92;
    localparam logic [7:0] GLYPH_6     = 8'h82;
    localparam logic [7:0] GLYPH_7     = 8'hF8;
    localparam logic [7:0] GLYPH_8     = 8'h80;
    localparam logic [7:0] GLYPH_9     = 8'h90;
    localparam logic [7:0] GLYPH_DASH  = 8'hBF;
    localparam logic [7:0] GLYPH_BLANK = 8'hFF;

    // Anything outside 0..9 renders dark rather than as garbage segments.
    function automatic logic [7:0] nibble_to_seg(input logic [3:0] n);
        logic [7:0] g;
        case (n)
            4'd0:    g = GLYPH_0;
            4'd1:    g = GLYPH_1;
            4'd2:    g = GLYPH_2;
            4'd3:    g = GLYPH_3;
            4'd4:    g = GLYPH_4;
            4'd5:    g = GLYPH_5;
            4'd6:    g = GLYPH_6;
            4'd7:    g = GLYPH_7;
            4'd8:    g = GLYPH_8;
            4'd9:    g = GLYPH_9;
            default: g = GLYPH_BLANK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/temp_bcd_display_bcd8.sv
// bcd8_dd
// Sequential double-dabble converter: 8-bit unsigned magnitude to three BCD
// digits, one shift-add-3 iteration per clock, eight iterations in total.
// Ports:
//   clk, reset    : system clock, synchronous active-high reset
//   start_i       : load mag_i and begin a conversion on this edge
//   mag_i[7:0]    : unsigned magnitude (0..255)
//   done_o        : high during the cycle whose edge performs the last iteration
//   hundreds_o, tens_o, units_o : BCD result, valid the cycle after done_o
module bcd8_dd
    import temp_disp_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start_i,
    input  logic [7:0] mag_i,
    output logic       done_o,
    output logic [3:0] hundreds_o,
    output logic [3:0] tens_o,
    output logic [3:0] units_o
);

    logic [7:0]  bin_q;
    logic [11:0] bcd_q;
    logic [2:0]  iter_q;
    logic        active_q;
    logic [10:0] adj_d;

    // Add-3 correction ahead of the shift. The hundreds nibble never reaches
    // 5 before the final shift (input is at most 255), so it passes through.
    always_comb begin
        adj_d[10:8] = bcd_q[10:8];
        adj_d[7:4]  = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
        adj_d[3:0]  = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
    end

    // Shift engine: start reloads, then eight shifts of {bcd, bin} left by one.
    always_ff @(posedge clk) begin
        if (reset) begin
            bin_q    <= '0;
            bcd_q    <= '0;
            iter_q   <= '0;
            active_q <= 1'b0;
        end else if (start_i) begin
            bin_q    <= mag_i;
            bcd_q    <= '0;
            iter_q   <= '0;
            active_q <= 1'b1;
        end else if (active_q) begin
            bcd_q  <= {adj_d, bin_q[7]};
            bin_q  <= {bin_q[6:0], 1'b0};
            iter_q <= iter_q + 3'd1;
            if (iter_q == 3'd7) begin
                active_q <= 1'b0;
            end
        end
    end

    assign done_o     = active_q && (iter_q == 3'd7);
    assign hundreds_o = bcd_q[11:8];
    assign tens_o     = bcd_q[7:4];
    assign units_o    = bcd_q[3:0];

endmodule

// File: rtl/temp_bcd_display.sv
// temp_bcd_display
// Takes signed 8-bit temperature bytes (degrees C), converts them to sign plus
// three BCD digits and scans them onto a 4-digit active-low seven-segment
// display. Strobes arriving while a conversion runs are held one-deep, newest
// value wins.
// Optional build macro: TEMP_STALE_EN -- when defined, STALE_CYCLES cycles
// without data_valid turn all digits into dashes and drop value_valid.
// Ports:
//   clk, reset       : system clock, synchronous active-high reset
//   data_rd[7:0]     : temperature byte, two's complement
//   data_valid       : one-cycle strobe qualifying data_rd
//   seg[7:0]         : segments, active low, seg[7]=dp (always off)
//   an[3:0]          : digit anodes, active-low one-hot, an[0]=rightmost
//   busy             : conversion in progress (CONV or LOAD)
//   value_valid      : a conversion has been committed to the display
module temp_bcd_display
    import temp_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
`ifdef TEMP_STALE_EN
    ,
    parameter int STALE_CYCLES = 100000000
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_rd,
    input  logic       data_valid,
    output logic [7:0] seg,
    output logic [3:0] an,
    output logic       busy,
    output logic       value_valid
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);

    state_e      state_q;
    logic        sign_q;
    logic        pend_q;
    logic [7:0]  pend_byte_q;
    logic        valid_q;
    logic [7:0]  disp_q [4];

    logic [RW-1:0] ref_q;
    logic [1:0]    idx_q;
    logic [3:0]    an_q;
    logic [7:0]    seg_q;

    logic        start_d;
    logic [7:0]  load_byte_d;
    logic [7:0]  load_mag_d;
    logic        dd_done;
    logic [3:0]  dd_hund;
    logic [3:0]  dd_tens;
    logic [3:0]  dd_units;
    logic [7:0]  glyph3_d;
    logic [7:0]  glyph2_d;
    logic [7:0]  glyph1_d;
    logic [7:0]  glyph0_d;

    // Pick the byte that starts the next conversion. In LOAD a strobe on the
    // same cycle is newer than anything pending, so it takes precedence.
    always_comb begin
        start_d     = 1'b0;
        load_byte_d = data_rd;
        case (state_q)
            IDLE: start_d = data_valid;
            LOAD: begin
                if (data_valid) begin
                    start_d = 1'b1;
                end else if (pend_q) begin
                    start_d     = 1'b1;
                    load_byte_d = pend_byte_q;
                end
            end
            default: start_d = 1'b0;
        endcase
        // Two's-complement magnitude; -128 maps to 8'd128 without overflow.
        load_mag_d = load_byte_d[7] ? (~load_byte_d + 8'd1) : load_byte_d;
    end

    bcd8_dd u_dd (
        .clk        (clk),
        .reset      (reset),
        .start_i    (start_d),
        .mag_i      (load_mag_d),
        .done_o     (dd_done),
        .hundreds_o (dd_hund),
        .tens_o     (dd_tens),
        .units_o    (dd_units)
    );

    // Leading-zero blanking: tens only shows when hundreds or tens is nonzero.
    always_comb begin
        glyph3_d = sign_q ? GLYPH_DASH : GLYPH_BLANK;
        glyph2_d = (dd_hund == 4'd0) ? GLYPH_BLANK : nibble_to_seg(dd_hund);
        glyph1_d = ((dd_hund == 4'd0) && (dd_tens == 4'd0)) ? GLYPH_BLANK
                                                            : nibble_to_seg(dd_tens);
        glyph0_d = nibble_to_seg(dd_units);
    end

`ifdef TEMP_STALE_EN
    localparam int SW = $clog2(STALE_CYCLES + 1);
    logic [SW-1:0] stale_q;
    logic          stale_hit;

    // Staleness timer: cleared by every strobe, saturates at STALE_CYCLES.
    // stale_hit marks the single edge on which it arrives there.
    assign stale_hit = !data_valid && (stale_q == SW'(STALE_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            stale_q <= '0;
        end else if (data_valid) begin
            stale_q <= '0;
        end else if (stale_q != SW'(STALE_CYCLES)) begin
            stale_q <= stale_q + 1'b1;
        end
    end
`endif

    // Control FSM with pending capture and display commit. The stale blanking
    // sits ahead of the case so a commit on the same edge would win.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            pend_q      <= 1'b0;
            pend_byte_q <= '0;
            valid_q     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                disp_q[i] <= GLYPH_DASH;
            end
        end else begin
`ifdef TEMP_STALE_EN
            if (stale_hit) begin
                for (int i = 0; i < 4; i++) begin
                    disp_q[i] <= GLYPH_DASH;
                end
                valid_q <= 1'b0;
            end
`endif
            case (state_q)
                IDLE: begin
                    if (data_valid) begin
                        sign_q  <= data_rd[7];
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    if (data_valid) begin
                        pend_q      <= 1'b1;
                        pend_byte_q <= data_rd;
                    end
                    if (dd_done) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    disp_q[3] <= glyph3_d;
                    disp_q[2] <= glyph2_d;
                    disp_q[1] <= glyph1_d;
                    disp_q[0] <= glyph0_d;
                    valid_q   <= 1'b1;
                    pend_q    <= 1'b0;
                    if (start_d) begin
                        sign_q  <= load_byte_d[7];
                        state_q <= CONV;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Display scan: on each refresh wrap the current digit is latched into
    // an/seg together, then the index moves on.
    always_ff @(posedge clk) begin
        if (reset) begin
            ref_q <= '0;
            idx_q <= '0;
            an_q  <= 4'hF;
            seg_q <= GLYPH_BLANK;
        end else if (ref_q == REF_LAST) begin
            ref_q <= '0;
            idx_q <= idx_q + 2'd1;
            an_q  <= ~(4'b0001 << idx_q);
            seg_q <= disp_q[idx_q];
        end else begin
            ref_q <= ref_q + 1'b1;
        end
    end

    assign seg         = seg_q;
    assign an          = an_q;
    assign busy        = (state_q != IDLE);
    assign value_valid = valid_q;

endmodule

// File: tb/tb_temp_bcd_display.sv
// tb_temp_bcd_display
// Directed bench for temp_bcd_display with REFRESH_DIV=4 (and STALE_CYCLES=200
// when TEMP_STALE_EN is defined). A cycle-level model of what the display must
// show is checked against an/seg/busy/value_valid on every falling edge, and
// directed sequences add hand-computed literal expectations.
module tb_temp_bcd_display;

    localparam int REFRESH_DIV = 4;
`ifdef TEMP_STALE_EN
    localparam int STALE_CYCLES = 200;
`endif
    localparam logic [7:0] GLY [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_rd = 8'h00;
    logic       data_valid = 1'b0;
    logic [7:0] seg;
    logic [3:0] an;
    logic       busy;
    logic       value_valid;

    int compared = 0;
    int mismatched = 0;
    bit checkEn = 1'b0;

    temp_bcd_display #(
        .REFRESH_DIV(REFRESH_DIV)
`ifdef TEMP_STALE_EN
        ,
        .STALE_CYCLES(STALE_CYCLES)
`endif
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .data_rd     (data_rd),
        .data_valid  (data_valid),
        .seg         (seg),
        .an          (an),
        .busy        (busy),
        .value_valid (value_valid)
    );

    always #5 clk = ~clk;

    // What the four digits must read for a committed byte, from plain arithmetic.
    function automatic logic [31:0] expectGlyphs(input logic [7:0] b);
        int v, m, h, t, u;
        logic [7:0] d3, d2, d1, d0;
        v  = int'($signed(b));
        m  = (v < 0) ? -v : v;
        h  = m / 100;
        t  = (m / 10) % 10;
        u  = m % 10;
        d3 = (v < 0) ? 8'hBF : 8'hFF;
        d2 = (h == 0) ? 8'hFF : GLY[h];
        d1 = (h == 0 && t == 0) ? 8'hFF : GLY[t];
        d0 = GLY[u];
        return {d3, d2, d1, d0};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Model state: converter occupancy, one-deep newest-wins hold slot,
    // committed digits, scan position and staleness timer.
    int          mTimer;
    logic [7:0]  mCur;
    bit          mPendValid;
    logic [7:0]  mPend;
    logic [31:0] mDisp;
    bit          mValid;
    int          mRef;
    int          mIdx;
    logic [3:0]  mAn;
    logic [7:0]  mSeg;
    int          mStale;

    // Model update: a conversion occupies 9 edges from its strobe to the commit.
    always @(posedge clk) begin
        if (reset) begin
            mTimer = 0; mPendValid = 0; mPend = '0; mCur = '0;
            mDisp = 32'hBFBFBFBF; mValid = 0;
            mRef = 0; mIdx = 0; mAn = 4'hF; mSeg = 8'hFF; mStale = 0;
        end else begin
            mRef++;
            if (mRef == REFRESH_DIV) begin
                mRef = 0;
                mAn  = ~(4'b0001 << mIdx);
                mSeg = mDisp[mIdx*8 +: 8];
                mIdx = (mIdx + 1) % 4;
            end
`ifdef TEMP_STALE_EN
            if (data_valid) begin
                mStale = 0;
            end else if (mStale < STALE_CYCLES) begin
                mStale++;
                if (mStale == STALE_CYCLES) begin
                    mDisp  = 32'hBFBFBFBF;
                    mValid = 0;
                end
            end
`endif
            if (mTimer > 0) begin
                mTimer--;
                if (data_valid) begin
                    mPendValid = 1;
                    mPend      = data_rd;
                end
                if (mTimer == 0) begin
                    mDisp  = expectGlyphs(mCur);
                    mValid = 1;
                    if (mPendValid) begin
                        mCur       = mPend;
                        mPendValid = 0;
                        mTimer     = 9;
                    end
                end
            end else if (data_valid) begin
                mCur   = data_rd;
                mTimer = 9;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("an", {28'b0, an}, {28'b0, mAn});
            checkOutput("seg", {24'b0, seg}, {24'b0, mSeg});
            checkOutput("busy", {31'b0, busy}, {31'b0, mTimer > 0});
            checkOutput("value_valid", {31'b0, value_valid}, {31'b0, mValid});
        end
    end

    // Strobe one byte; called on a falling edge, returns on the next one.
    task automatic applyStimulus(input logic [7:0] b);
        data_rd    = b;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic waitIdle(input string tag);
        int g = 0;
        while (busy && g < 40) begin
            @(negedge clk);
            g++;
        end
        if (busy) checkOutput({tag, "_idle_timeout"}, {31'b0, busy}, 32'd0);
    endtask

    // Let every digit refresh once, then read each one off the scan.
    task automatic checkDigits(input string tag, input logic [31:0] expv);
        logic [3:0] target;
        repeat (4 * REFRESH_DIV) @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            int g = 0;
            target = ~(4'b0001 << d);
            while (an !== target && g < 8 * REFRESH_DIV) begin
                @(negedge clk);
                g++;
            end
            if (an !== target)
                checkOutput($sformatf("%s_scan%0d_timeout", tag, d), {28'b0, an}, {28'b0, target});
            checkOutput($sformatf("%s_digit%0d", tag, d), {24'b0, seg}, {24'b0, expv[d*8 +: 8]});
        end
    endtask

    task automatic countBusy(input string tag, input int expCycles);
        int n = 0;
        while (busy && n < 64) begin
            n++;
            @(negedge clk);
        end
        checkOutput(tag, n, expCycles);
    endtask

    initial begin
        #100000;
        mismatched++;
        $display("[TB] FAIL watchdog: simulation did not complete, expected finish before t=100000");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        // Model pins: hand-derived digit patterns.
        checkOutput("model_25",   expectGlyphs(8'h19), 32'hFFFFA492);
        checkOutput("model_m128", expectGlyphs(8'h80), 32'hBFF9A480);
        checkOutput("model_m1",   expectGlyphs(8'hFF), 32'hBFFFFFF9);
        checkOutput("model_100",  expectGlyphs(8'h64), 32'hFFF9C0C0);
        checkOutput("model_10",   expectGlyphs(8'h0A), 32'hFFFFF9C0);
        checkOutput("model_0",    expectGlyphs(8'h00), 32'hFFFFFFC0);
        checkOutput("model_127",  expectGlyphs(8'h7F), 32'hFFF9A4F8);

        // Reset state and first scan timing.
        repeat (2) @(negedge clk);
        checkEn = 1'b1;
        checkOutput("rst_an", {28'b0, an}, 32'hF);
        checkOutput("rst_seg", {24'b0, seg}, 32'hFF);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_valid", {31'b0, value_valid}, 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("scan_before_first", {28'b0, an}, 32'hF);
        @(negedge clk);
        checkOutput("scan_first_an", {28'b0, an}, 32'hE);
        checkOutput("scan_first_seg", {24'b0, seg}, 32'hBF);
        repeat (16) @(negedge clk);
        checkDigits("idle", 32'hBFBFBFBF);
        checkOutput("idle_valid", {31'b0, value_valid}, 32'd0);

        // +25: busy for 9 cycles, then value_valid.
        applyStimulus(8'h19);
        countBusy("busy_len_25", 9);
        checkOutput("valid_after_25", {31'b0, value_valid}, 32'd1);
        checkDigits("d25", 32'hFFFFA492);

        // -128 then -1.
        applyStimulus(8'h80);
        waitIdle("m128");
        checkDigits("dm128", 32'hBFF9A480);
        applyStimulus(8'hFF);
        waitIdle("m1");
        checkDigits("dm1", 32'hBFFFFFF9);

        // 5, then 10 and 100 during CONV: 10 is overwritten by 100.
        applyStimulus(8'h05);
        applyStimulus(8'h0A);
        applyStimulus(8'h64);
        countBusy("busy_len_chain", 16);
        checkDigits("d100", 32'hFFF9C0C0);

        // Reset at iteration 4 with a byte pending.
        applyStimulus(8'h30);
        applyStimulus(8'h11);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("midrst_seg", {24'b0, seg}, 32'hFF);
        checkOutput("midrst_an", {28'b0, an}, 32'hF);
        checkOutput("midrst_busy", {31'b0, busy}, 32'd0);
        checkOutput("midrst_valid", {31'b0, value_valid}, 32'd0);
        repeat (20) @(negedge clk);
        checkOutput("midrst_no_pending", {31'b0, busy}, 32'd0);
        applyStimulus(8'hE7);
        waitIdle("m25");
        checkDigits("dm25", 32'hBFFFA492);

`ifdef TEMP_STALE_EN
        applyStimulus(8'h00);
        waitIdle("zero");
        checkDigits("d0", 32'hFFFFFFC0);
        repeat (STALE_CYCLES) @(negedge clk);
        checkOutput("stale_valid", {31'b0, value_valid}, 32'd0);
        checkDigits("stale", 32'hBFBFBFBF);
        applyStimulus(8'h7F);
        waitIdle("d127");
        checkOutput("stale_restored_valid", {31'b0, value_valid}, 32'd1);
        checkDigits("d127", 32'hFFF9A4F8);
`endif

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
